// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Owns the PC, issues word fetches over a req/gnt/rvalid handshake (one
// outstanding at most), buffers returned words in a small FIFO and presents
// {id_pc, id_ir} to decode. EX redirects flush the FIFO and squash any fetch
// still in flight.
// Optional build macro FETCH_PERF_CNT_EN adds perf_stall_cnt / perf_flush_cnt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_ir,
  output logic [31:0] id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
  } fetch_entry_t;

  fetch_state_e  state;
  logic [31:0]   fetch_pc;
  logic [31:0]   issue_pc;

  fetch_entry_t  fifo_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic          st_wait;
  logic          pop, push, room;
  logic [CW:0]   occ;

  // Occupancy seen by a new request: buffered words plus the one in flight
  // (a squashed fetch in DROP never lands, so it reserves no slot).
  assign st_wait   = (state == S_WAIT);
  assign id_valid  = (count != '0);
  assign pop       = id_valid & id_ready;
  assign push      = st_wait & imem_rvalid & ~redirect;
  assign occ       = {1'b0, count} + (CW+1)'(st_wait) - (CW+1)'(pop);
  assign room      = (occ < (CW+1)'(DEPTH));

  // Request may overlap the returning response, giving back-to-back issue.
  assign imem_req  = rstn & ~redirect & room & ((state == S_IDLE) | imem_rvalid);
  assign imem_addr = fetch_pc;

  // Head is shown combinationally; NOP/0 when the FIFO is empty.
  assign id_ir     = id_valid ? fifo_q[rd_ptr].ir : NOP;
  assign id_pc     = id_valid ? fifo_q[rd_ptr].pc : 32'h0;

  // PC and outstanding-fetch tracking; redirect overrides everything.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      issue_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'h3;
      case (state)
        S_WAIT:  state <= imem_rvalid ? S_IDLE : S_DROP;
        S_DROP:  if (imem_rvalid) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end else if (imem_req && imem_gnt) begin
      fetch_pc <= fetch_pc + 32'd4;
      issue_pc <= fetch_pc;
      state    <= S_WAIT;
    end else if (state != S_IDLE && imem_rvalid) begin
      state    <= S_IDLE;
    end
  end

  // FIFO pointers and count; a redirect empties it even if a pop coincides.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; contents are only visible through a valid count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: issue_pc, ir: imem_rdata};
  end

`ifdef FETCH_PERF_CNT_EN
  // Starvation and flush counters; free-running, wrap, cleared only by reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (!id_valid) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (redirect)  perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule
